// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//   Bundles every handshake and bus signal around the RAM port arbiter.
//   Two requesters share one single-port RAM: CPU (default priority) and host.
//   Request side : *_req, *_we, *_addr, *_wdata in; *_gnt, *_rdata, *_rvalid out.
//   RAM side     : ram_addr, ram_wdata, ram_rden, ram_wren out; ram_rdata in.
//   Status       : host_wait (host pending but not granted this cycle).
//   Modports     : slave  - arbiter view (takes requests, drives the RAM)
//                  master - environment view (requesters plus the RAM itself)
interface ram_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          host_wait;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_rden;
  logic          ram_wren;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid, host_wait,
    output ram_addr, ram_wdata, ram_rden, ram_wren,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid, host_wait,
    input  ram_addr, ram_wdata, ram_rden, ram_wren,
    output ram_rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port synchronous RAM between the CPU and the host port.
//   The CPU wins by default; after STARVE_LIMIT consecutive cycles of the host
//   being denied, the host is granted for one cycle even if the CPU requests.
//   Read data comes back one cycle after the granted read and is steered to
//   whichever requester issued that read.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous reset, active-low
//     bus  - ram_port_arbiter_if.slave (requester handshakes + RAM drive)
module ram_port_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_port_arbiter_if.slave    bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {ARB, FORCE} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_e;

  state_e        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  owner_e        rd_owner_q, rd_owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;

  logic          cpu_gnt, host_gnt, host_wait;
  logic          ram_rden, ram_wren;
  logic          cpu_rvalid, host_rvalid;
  logic [DW-1:0] cpu_rdata, host_rdata;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = 4'd0;
    rd_owner_d   = OWN_NONE;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_gnt      = 1'b0;
    host_gnt     = 1'b0;
    ram_rden     = 1'b0;
    ram_wren     = 1'b0;

    // Grants are combinational but gated by reset so nothing leaks out while
    // rst is held low, even though the registers are already cleared.
    if (rst) begin
      if (state_q == FORCE && bus.host_req) begin
        host_gnt = 1'b1;
      end else if (bus.cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (bus.host_req) begin
        host_gnt = 1'b1;
      end
    end

    host_wait = bus.host_req & ~host_gnt;

    // Drive the RAM from the winner; with no winner the address/data stay at
    // the last granted values so the RAM pins do not toggle needlessly.
    if (cpu_gnt) begin
      addr_d     = bus.cpu_addr;
      wdata_d    = bus.cpu_wdata;
      ram_wren   = bus.cpu_we;
      ram_rden   = ~bus.cpu_we;
      rd_owner_d = bus.cpu_we ? OWN_NONE : OWN_CPU;
    end else if (host_gnt) begin
      addr_d     = bus.host_addr;
      wdata_d    = bus.host_wdata;
      ram_wren   = bus.host_we;
      ram_rden   = ~bus.host_we;
      rd_owner_d = bus.host_we ? OWN_NONE : OWN_HOST;
    end

    if (host_wait) begin
      wait_cnt_d = (wait_cnt_q >= LIMIT) ? LIMIT : wait_cnt_q + 4'd1;
    end

    // FORCE lasts exactly one cycle; it is entered on the edge where the
    // starvation count reaches the limit.
    case (state_q)
      ARB:     if (host_wait && wait_cnt_q == LIMIT - 4'd1) state_d = FORCE;
      FORCE:   state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // The RAM has one cycle of read latency, so the owner registered at the
  // grant edge sees ram_rdata directly; the other side keeps its last value.
  assign cpu_rvalid   = (rd_owner_q == OWN_CPU);
  assign host_rvalid  = (rd_owner_q == OWN_HOST);
  assign cpu_rdata    = cpu_rvalid  ? bus.ram_rdata : cpu_rdata_q;
  assign host_rdata   = host_rvalid ? bus.ram_rdata : host_rdata_q;
  assign cpu_rdata_d  = cpu_rdata;
  assign host_rdata_d = host_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB;
      wait_cnt_q   <= 4'd0;
      rd_owner_q   <= OWN_NONE;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      rd_owner_q   <= rd_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.host_wait   = host_wait;
  assign bus.cpu_rvalid  = cpu_rvalid;
  assign bus.host_rvalid = host_rvalid;
  assign bus.cpu_rdata   = cpu_rdata;
  assign bus.host_rdata  = host_rdata;
  assign bus.ram_addr    = (cpu_gnt | host_gnt) ? addr_d  : addr_q;
  assign bus.ram_wdata   = (cpu_gnt | host_gnt) ? wdata_d : wdata_q;
  assign bus.ram_rden    = ram_rden;
  assign bus.ram_wren    = ram_wren;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LIM = 3;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // The shared RAM: synchronous, one cycle read latency.
  logic [DW-1:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    bus.ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_rden) bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  // Reference model: CPU first, unless the host has been refused LIM cycles
  // in a row; a read's data is whatever the memory held when it was granted.
  logic [DW-1:0] shadow [0:255];
  int            denied;
  int            pend;        // 0 none, 1 cpu, 2 host
  logic [DW-1:0] pend_val;
  logic [DW-1:0] e_crd, e_hrd, hold_wd, e_wd;
  logic [AW-1:0] hold_a, e_a;
  logic          hp, egc, egh, e_we;

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i * 7 + 3);
    denied = 0; pend = 0; pend_val = '0;
    e_crd = '0; e_hrd = '0; hold_a = '0; hold_wd = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_cpu_gnt", bus.cpu_gnt, 0);
        chk("rst_host_gnt", bus.host_gnt, 0);
        chk("rst_rden", bus.ram_rden, 0);
        chk("rst_wren", bus.ram_wren, 0);
        chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("rst_host_rvalid", bus.host_rvalid, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_host_rdata", bus.host_rdata, 0);
        chk("rst_host_wait", bus.host_wait, bus.host_req);
        denied = 0; pend = 0; e_crd = '0; e_hrd = '0; hold_a = '0; hold_wd = '0;
      end else begin
        if (pend == 1) e_crd = pend_val;
        if (pend == 2) e_hrd = pend_val;
        chk("cpu_rvalid", bus.cpu_rvalid, (pend == 1));
        chk("host_rvalid", bus.host_rvalid, (pend == 2));
        chk("cpu_rdata", bus.cpu_rdata, e_crd);
        chk("host_rdata", bus.host_rdata, e_hrd);
        hp  = bus.host_req && (denied >= LIM);
        egc = bus.cpu_req && !hp;
        egh = bus.host_req && !egc;
        chk("cpu_gnt", bus.cpu_gnt, egc);
        chk("host_gnt", bus.host_gnt, egh);
        chk("host_wait", bus.host_wait, bus.host_req && !egh);
        if (egc) begin
          e_a = bus.cpu_addr; e_wd = bus.cpu_wdata; e_we = bus.cpu_we;
        end else begin
          e_a = bus.host_addr; e_wd = bus.host_wdata; e_we = bus.host_we;
        end
        pend = 0;
        if (egc || egh) begin
          chk("ram_addr", bus.ram_addr, e_a);
          chk("ram_wren", bus.ram_wren, e_we);
          chk("ram_rden", bus.ram_rden, !e_we);
          if (e_we) begin
            chk("ram_wdata", bus.ram_wdata, e_wd);
            shadow[e_a] = e_wd;
          end else begin
            pend = egc ? 1 : 2;
            pend_val = shadow[e_a];
          end
          hold_a = e_a; hold_wd = e_wd;
        end else begin
          chk("idle_ram_addr", bus.ram_addr, hold_a);
          chk("idle_ram_wdata", bus.ram_wdata, hold_wd);
          chk("idle_rden_wren", {bus.ram_rden, bus.ram_wren}, 0);
        end
        if (bus.host_req && !egh) denied = (denied < LIM) ? denied + 1 : denied;
        else denied = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drv(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic host_drv(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.host_req = req; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
  endtask

  logic cg, hg;

  initial begin
    rst = 1'b0;
    cpu_drv(1, 0, 8'h00, 8'h00);
    host_drv(1, 0, 8'h00, 8'h00);

    // Reset holds off both requesters.
    repeat (2) @(negedge clk);
    chk("lit_rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("lit_rst_host_gnt", bus.host_gnt, 0);
    step(); rst = 1'b1;
    @(negedge clk);
    chk("lit_after_rst_cpu_gnt", bus.cpu_gnt, 1);
    step(); cpu_drv(0, 0, 8'h00, 8'h00);        // host still waiting, now served
    @(negedge clk);
    chk("lit_host_served", bus.host_gnt, 1);
    step(); host_drv(0, 0, 8'h00, 8'h00);

    // CPU read of a value the host downloaded.
    host_drv(1, 1, 8'h10, 8'h5A);
    step(); host_drv(0, 0, 8'h00, 8'h00); cpu_drv(1, 0, 8'h10, 8'h00);
    @(negedge clk);
    chk("lit_cpu_rd_gnt", bus.cpu_gnt, 1);
    chk("lit_cpu_rd_addr", bus.ram_addr, 8'h10);
    chk("lit_cpu_rd_rden", bus.ram_rden, 1);
    step(); cpu_drv(0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("lit_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("lit_cpu_rdata", bus.cpu_rdata, 8'h5A);
    chk("lit_cpu_rd_host_rvalid", bus.host_rvalid, 0);

    // Contention: period-4 pattern, host forced every fourth cycle.
    step(); cpu_drv(1, 0, 8'h00, 8'h00); host_drv(1, 0, 8'h01, 8'h00);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("lit_cont_cpu_gnt", bus.cpu_gnt, (k % 4) != 3);
      chk("lit_cont_host_wait", bus.host_wait, (k % 4) != 3);
      step();
    end
    cpu_drv(0, 0, 8'h00, 8'h00); host_drv(0, 0, 8'h00, 8'h00);

    // Host write then CPU read of the same address.
    step(); host_drv(1, 1, 8'h20, 8'h33);
    step(); host_drv(0, 0, 8'h00, 8'h00); cpu_drv(1, 0, 8'h20, 8'h00);
    step(); cpu_drv(0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("lit_raw_rvalid", bus.cpu_rvalid, 1);
    chk("lit_raw_rdata", bus.cpu_rdata, 8'h33);

    // Interleaved reads, second one forced for the host.
    step(); host_drv(1, 1, 8'h01, 8'hAA);
    step(); host_drv(1, 1, 8'h02, 8'hBB);
    step(); cpu_drv(1, 0, 8'h01, 8'h00); host_drv(1, 0, 8'h02, 8'h00);
    repeat (3) step();
    @(negedge clk);
    chk("lit_il_host_gnt", bus.host_gnt, 1);
    chk("lit_il_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("lit_il_cpu_rdata", bus.cpu_rdata, 8'hAA);
    step(); cpu_drv(0, 0, 8'h00, 8'h00); host_drv(0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("lit_il_host_rvalid", bus.host_rvalid, 1);
    chk("lit_il_host_rdata", bus.host_rdata, 8'hBB);
    chk("lit_il_cpu_rvalid2", bus.cpu_rvalid, 0);

    // Reset during a pending CPU read, with the host partly starved.
    step(); cpu_drv(1, 0, 8'h10, 8'h00); host_drv(1, 0, 8'h01, 8'h00);
    step();
    @(negedge clk);
    chk("lit_mr_cpu_gnt", bus.cpu_gnt, 1);
    #2 rst = 1'b0;
    step();
    @(negedge clk);
    chk("lit_mr_cpu_rvalid", bus.cpu_rvalid, 0);
    step(); rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_mr_host_gnt", bus.host_gnt, k == 3);
      step();
    end
    cpu_drv(0, 0, 8'h00, 8'h00); host_drv(0, 0, 8'h00, 8'h00);

    // Randomized traffic, requests held until granted.
    cg = 1'b1; hg = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!bus.cpu_req || cg)
        cpu_drv($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 15)), 8'($urandom));
      if (!bus.host_req || hg)
        host_drv($urandom_range(0, 99) < 50, 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 15)), 8'($urandom));
      @(negedge clk);
      cg = bus.cpu_gnt; hg = bus.host_gnt;
    end

    step();
    cpu_drv(0, 0, 8'h00, 8'h00); host_drv(0, 0, 8'h00, 8'h00);
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port synchronous `ram` between two requesters: the CPU core (fetch, LD, ST) and a host/loader port (program download, memory inspection).
- CPU has default priority; a starvation counter guarantees the host forward progress.
- Sits between `cpu` and `ram`. Drives the RAM address, write data and read/write enables, and routes the 1-cycle-latency read data back to the owner of the read.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- STARVE_LIMIT, 3, consecutive denied host-request cycles before the host is force-granted (range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low (asserted at 0); clears all state immediately.
- cpu_req  input  1  CPU requests an access this cycle.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  AW  CPU address.
- cpu_wdata  input  DW  CPU write data.
- cpu_gnt  output  1  CPU access accepted this cycle (combinational).
- cpu_rdata  output  DW  read data for CPU.
- cpu_rvalid  output  1  cpu_rdata valid (one cycle after a granted CPU read).
- host_req  input  1  host requests an access this cycle.
- host_we  input  1  1 = write, 0 = read.
- host_addr  input  AW  host address.
- host_wdata  input  DW  host write data.
- host_gnt  output  1  host access accepted this cycle (combinational).
- host_rdata  output  DW  read data for host.
- host_rvalid  output  1  host_rdata valid (one cycle after a granted host read).
- ram_addr  output  AW  to ram address.
- ram_wdata  output  DW  to ram data_in.
- ram_rden  output  1  to ram rden.
- ram_wren  output  1  to ram wren.
- ram_rdata  input  DW  from ram data_out.
- host_wait  output  1  host_req pending and not granted this cycle.

Behaviour:
- Reset (rst=0, async):
  - state=ARB, wait_cnt=0, rd_owner=NONE.
  - All gnt, rvalid, ram_rden, ram_wren = 0; ram_addr=0; ram_wdata=0; *_rdata=0.
  - While rst=0, grants are forced to 0 regardless of requests.
- At most one grant per cycle; cpu_gnt and host_gnt are never both 1.
- A transaction completes in the cycle where req=1 and gnt=1. A requester not granted holds req/we/addr/wdata stable until granted.
- State ARB:
  - cpu_req=1: cpu_gnt=1.
  - else host_req=1: host_gnt=1.
- State FORCE:
  - host_req=1: host_gnt=1, even if cpu_req=1.
  - host_req=0: behaves as ARB.
- Transitions:
  - ARB -> FORCE at the edge where wait_cnt increments to STARVE_LIMIT.
  - FORCE -> ARB after exactly one cycle.
- wait_cnt (4 bits):
  - increments when host_req=1 and host_gnt=0;
  - clears when host_gnt=1 or host_req=0;
  - saturates at STARVE_LIMIT.
- RAM drive (combinational from the winner):
  - ram_addr/ram_wdata = winner's addr/wdata;
  - ram_wren = winner's we;
  - ram_rden = ~winner's we.
  - No winner: rden=0, wren=0, addr/wdata hold their last granted value (registered copy).
- Read return:
  - rd_owner register captures CPU/HOST/NONE at each edge.
  - Next cycle: owner's rvalid=1 and owner's rdata = ram_rdata.
  - Non-owner rdata holds its previous value; rvalid is a 1-cycle pulse per read.
- Back-to-back reads: a grant in cycle N+1 does not disturb the rvalid/rdata of the read granted in cycle N.
- Writes produce no rvalid.
- Same-cycle read-after-write to one address from different requesters: order equals grant order; the later read returns the newly written value.
- host_wait = host_req & ~host_gnt.
- Reset asserted mid-read: rvalid for that read is suppressed (rd_owner cleared). No partial write is guaranteed once rst is low before the edge.

Test Plan:
- Reset: rst=0 with cpu_req=host_req=1 -> all gnt=0, rden=wren=0, rvalid=0. Release rst -> next cycle cpu_gnt=1.
- CPU read: ram[0x10]=0x5A; cpu_req=1, we=0, addr=0x10 -> cycle N cpu_gnt=1, ram_addr=0x10, rden=1; cycle N+1 cpu_rvalid=1, cpu_rdata=0x5A, host_rvalid=0.
- Contention, STARVE_LIMIT=3: cpu_req and host_req held high -> CPU granted cycles 0..2, host_wait=1 in those cycles, host granted cycle 3, CPU cycle 4; pattern repeats with period 4.
- Host write then CPU read: host writes 0x33 to 0x20 in cycle N; CPU reads 0x20 in cycle N+1 -> cpu_rdata=0x33 in cycle N+2.
- Interleaved reads: CPU read 0x01 (=0xAA) in cycle N, host read 0x02 (=0xBB) in cycle N+1 (forced) -> cpu_rvalid/0xAA at N+1, host_rvalid/0xBB at N+2, no overlap.
- Reset mid-read: CPU read granted at N; rst=0 before edge N+1 -> cpu_rvalid stays 0, wait_cnt=0.
